// File: rtl/mag_pipe_if.sv
// -----------------------------------------------------------------------------
// mag_pipe_if
// Purpose : Groups the input and output valid/ready handshakes of mag_pipe.
//           Clock and reset are not part of this bundle.
// Parameter:
//   N          data width (two's complement)
// Signals :
//   in_valid   producer -> block   input word present
//   in_ready   block -> producer   word accepted this cycle
//   in_data    producer -> block   signed operand [N-1:0]
//   mode       producer -> block   00 pass, 01 |A|, 10 -A, 11 -|A|
//   out_valid  block -> consumer   result present
//   out_ready  consumer -> block   result taken this cycle
//   out_data   block -> consumer   result [N-1:0]
//   out_ovf    block -> consumer   result came from MIN under |A| or -A
// Modports: master = producer/consumer side (testbench), slave = mag_pipe.
// -----------------------------------------------------------------------------
interface mag_pipe_if #(
  parameter int N = 11
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic [1:0]   mode;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_ovf;

  modport master (
    output in_valid, in_data, mode, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data, mode, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/mag_pipe.sv
// -----------------------------------------------------------------------------
// mag_pipe
// Purpose : Two-stage valid/ready pipeline computing pass, magnitude, negate or
//           negative magnitude of a signed N-bit operand, flagging the overflow
//           case (operand = MIN under magnitude or negate) and counting
//           overflowing output transfers in a saturating counter.
// Parameters:
//   N    data width in two's-complement bits (N >= 2)
//   CW   overflow counter width
// Ports:
//   i_clk       clock, all state changes on the rising edge
//   i_rst_n     asynchronous active-low reset
//   bus         mag_pipe_if.slave, input and output handshakes + data
//   i_cnt_clr   synchronous clear of o_ovf_cnt (wins over an increment)
//   o_ovf_cnt   saturating count of output transfers with out_ovf = 1
// Build option:
//   MAG_PIPE_SAT_EN  defined   -> overflowing |A| / -A outputs MAX
//                    undefined -> overflowing |A| / -A outputs MIN (wrap)
// -----------------------------------------------------------------------------
module mag_pipe #(
  parameter int N  = 11,
  parameter int CW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  mag_pipe_if.slave     bus,
  input  logic          i_cnt_clr,
  output logic [CW-1:0] o_ovf_cnt
);

  localparam logic [N-1:0]  MIN_VAL = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0]  MAX_VAL = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]  ONE_N   = {{(N-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  // Stage 1: captured operand, mode and MIN-detect flag.
  logic         r_s1_valid;
  logic [N-1:0] r_s1_data;
  logic [1:0]   r_s1_mode;
  logic         r_s1_min;

  // Stage 2: registered result, drives the output port directly.
  logic         r_s2_valid;
  logic [N-1:0] r_s2_data;
  logic         r_s2_ovf;

  logic [CW-1:0] r_ovf_cnt;

  logic         w_s2_ready;
  logic         w_in_ready;
  logic         w_in_xfer;
  logic         w_out_xfer;
  logic [N-1:0] w_neg;
  logic [N-1:0] w_result;
  logic         w_ovf;

  // Handshake. Stage 2 can take a word when empty or when its word leaves
  // this cycle; stage 1 likewise with respect to stage 2. None of this looks
  // at in_valid, so in_ready is free of any combinational path from it.
  assign w_out_xfer = r_s2_valid & bus.out_ready;
  assign w_s2_ready = ~r_s2_valid | bus.out_ready;
  assign w_in_ready = ~r_s1_valid | w_s2_ready;
  assign w_in_xfer  = bus.in_valid & w_in_ready;

  // Result computation from stage-1 contents.
  always_comb begin
    w_neg    = ~r_s1_data + ONE_N;
    w_ovf    = r_s1_min & ((r_s1_mode == 2'b01) | (r_s1_mode == 2'b10));
    w_result = r_s1_data;
    case (r_s1_mode)
      2'b00:   w_result = r_s1_data;
      2'b01:   w_result = r_s1_data[N-1] ? w_neg : r_s1_data;
      2'b10:   w_result = w_neg;
      default: w_result = r_s1_data[N-1] ? r_s1_data : w_neg;
    endcase
`ifdef MAG_PIPE_SAT_EN
    if (w_ovf) begin
      w_result = MAX_VAL;
    end
`else
    // Negating MIN already wraps to MIN; made explicit for symmetry.
    if (w_ovf) begin
      w_result = MIN_VAL;
    end
`endif
  end

  // Stage 1 register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_mode  <= 2'b00;
      r_s1_min   <= 1'b0;
    end else begin
      if (w_in_ready) begin
        r_s1_valid <= bus.in_valid;
      end
      if (w_in_xfer) begin
        r_s1_data <= bus.in_data;
        r_s1_mode <= bus.mode;
        r_s1_min  <= (bus.in_data == MIN_VAL);
      end
    end
  end

  // Stage 2 register; holds steady while out_valid && !out_ready.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_ovf   <= 1'b0;
    end else if (w_s2_ready) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data <= w_result;
        r_s2_ovf  <= w_ovf;
      end
    end
  end

  // Saturating overflow counter; clear has priority.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ovf_cnt <= '0;
    end else if (i_cnt_clr) begin
      r_ovf_cnt <= '0;
    end else if (w_out_xfer && r_s2_ovf && (r_ovf_cnt != CNT_MAX)) begin
      r_ovf_cnt <= r_ovf_cnt + CNT_ONE;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_s2_valid;
  assign bus.out_data  = r_s2_data;
  assign bus.out_ovf   = r_s2_ovf;
  assign o_ovf_cnt     = r_ovf_cnt;

endmodule

// File: tb/tb_mag_pipe.sv
// -----------------------------------------------------------------------------
// tb_mag_pipe
// Purpose : Self-checking bench for mag_pipe (N=11, CW=2). Expected results are
//           queued when an input transfer happens and compared in order when
//           an output transfer happens. Covers the directed vector table,
//           backpressure, counter saturation/clear, random traffic and reset.
// -----------------------------------------------------------------------------
module tb_mag_pipe;
  localparam int N  = 11;
  localparam int CW = 2;
  localparam logic [N-1:0] MIN_V = 11'h400;
`ifdef MAG_PIPE_SAT_EN
  localparam logic [N-1:0] OVF_RES = 11'h3FF;
`else
  localparam logic [N-1:0] OVF_RES = 11'h400;
`endif

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          cnt_clr = 1'b0;
  logic [CW-1:0] ovf_cnt;

  mag_pipe_if #(.N(N)) u_if ();

  mag_pipe #(.N(N), .CW(CW)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .bus       (u_if),
    .i_cnt_clr (cnt_clr),
    .o_ovf_cnt (ovf_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] d;
    logic         ovf;
    int           cyc;
    bit           lat;
  } exp_t;

  typedef struct {
    logic [N-1:0] a;
    logic [1:0]   m;
    logic [N-1:0] exp_d;
    logic         exp_ovf;
  } vec_t;

  exp_t         sb_q[$];
  vec_t         vecs[14];
  int           checks     = 0;
  int           failures   = 0;
  int           cyc        = 0;
  int           model_cnt  = 0;
  int           in_xfers   = 0;
  bit           lat_mode   = 1'b0;
  bit           rnd_done   = 1'b0;
  bit           prev_stall = 1'b0;
  logic [N-1:0] prev_data;
  logic         prev_ovf;
  logic [N-1:0] pend_d;
  logic         pend_ovf;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Independent reference: arithmetic on signed integers.
  function automatic void model(input logic [N-1:0] a, input logic [1:0] m,
                                output logic [N-1:0] r, output logic o);
    int sa;
    int v;
    sa = int'($signed(a));
    o  = (sa == -(1 << (N-1))) && (m == 2'd1 || m == 2'd2);
    case (m)
      2'd0:    v = sa;
      2'd1:    v = (sa < 0) ? -sa : sa;
      2'd2:    v = -sa;
      default: v = (sa > 0) ? -sa : sa;
    endcase
`ifdef MAG_PIPE_SAT_EN
    if (o) v = (1 << (N-1)) - 1;
`endif
    r = N'(v);
  endfunction

  always @(posedge clk) cyc++;

  // Scoreboard / monitor, sampling on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
      model_cnt  = 0;
    end else begin
      chk("ovf_cnt", 32'(ovf_cnt), 32'(model_cnt));
      if (prev_stall) begin
        chk("hold_valid", 32'(u_if.out_valid), 32'd1);
        chk("hold_data", 32'(u_if.out_data), 32'(prev_data));
        chk("hold_ovf", 32'(u_if.out_ovf), 32'(prev_ovf));
      end
      if (u_if.out_valid && u_if.out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%0h expected=none (t=%0t)", u_if.out_data, $time);
        end else begin
          e = sb_q.pop_front();
          chk("out_data", 32'(u_if.out_data), 32'(e.d));
          chk("out_ovf", 32'(u_if.out_ovf), 32'(e.ovf));
          if (e.lat) chk("latency", 32'(cyc - e.cyc), 32'd2);
          if (!cnt_clr && e.ovf && model_cnt < (1 << CW) - 1) model_cnt++;
        end
      end
      if (cnt_clr) model_cnt = 0;
      if (u_if.in_valid && u_if.in_ready) begin
        e.d = pend_d; e.ovf = pend_ovf; e.cyc = cyc; e.lat = lat_mode;
        sb_q.push_back(e);
        in_xfers++;
      end
      prev_stall = u_if.out_valid && !u_if.out_ready;
      prev_data  = u_if.out_data;
      prev_ovf   = u_if.out_ovf;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [N-1:0] a, input logic [1:0] m,
                      input logic [N-1:0] ed, input logic eo);
    bit ok;
    ok = 1'b0;
    pend_d = ed; pend_ovf = eo;
    u_if.in_data = a; u_if.mode = m; u_if.in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (u_if.in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL send_timeout actual=in_ready_low expected=accept (t=%0t)", $time);
    end
    @(posedge clk); #1;
    u_if.in_valid = 1'b0;
  endtask

  // Returns on the falling edge at which the last output transfer is seen.
  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual=%0d expected=0 words pending", sb_q.size());
    end
  endtask

  task automatic send_model(input logic [N-1:0] a, input logic [1:0] m);
    logic [N-1:0] r;
    logic o;
    model(a, m, r, o);
    send(a, m, r, o);
  endtask

  initial begin
    int base;
    vecs[0]  = '{11'h005, 2'b01, 11'h005, 1'b0};
    vecs[1]  = '{11'h7FB, 2'b01, 11'h005, 1'b0};
    vecs[2]  = '{11'h7FB, 2'b10, 11'h005, 1'b0};
    vecs[3]  = '{11'h400, 2'b01, OVF_RES, 1'b1};
    vecs[4]  = '{11'h400, 2'b11, 11'h400, 1'b0};
    vecs[5]  = '{11'h400, 2'b10, OVF_RES, 1'b1};
    vecs[6]  = '{11'h400, 2'b00, 11'h400, 1'b0};
    vecs[7]  = '{11'h3FF, 2'b10, 11'h401, 1'b0};
    vecs[8]  = '{11'h3FF, 2'b11, 11'h401, 1'b0};
    vecs[9]  = '{11'h000, 2'b10, 11'h000, 1'b0};
    vecs[10] = '{11'h123, 2'b00, 11'h123, 1'b0};
    vecs[11] = '{11'h7FF, 2'b11, 11'h7FF, 1'b0};
    vecs[12] = '{11'h7FF, 2'b01, 11'h001, 1'b0};
    vecs[13] = '{11'h000, 2'b11, 11'h000, 1'b0};

    u_if.in_valid = 1'b0; u_if.in_data = '0; u_if.mode = 2'b00; u_if.out_ready = 1'b0;

    // Reset state, before any clock edge.
    #3;
    chk("rst_in_ready", 32'(u_if.in_ready), 32'd1);
    chk("rst_out_valid", 32'(u_if.out_valid), 32'd0);
    chk("rst_out_data", 32'(u_if.out_data), 32'd0);
    chk("rst_out_ovf", 32'(u_if.out_ovf), 32'd0);
    chk("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(u_if.in_ready), 32'd1);
    @(posedge clk); #1;

    // Directed table, no backpressure, latency checked.
    u_if.out_ready = 1'b1;
    lat_mode = 1'b1;
    for (int i = 0; i < 14; i++) send(vecs[i].a, vecs[i].m, vecs[i].exp_d, vecs[i].exp_ovf);
    u_if.in_valid = 1'b0;
    lat_mode = 1'b0;
    drain();
    @(posedge clk); #1;

    // Backpressure: 5 words with the consumer stalled.
    u_if.out_ready = 1'b0;
    base = in_xfers;
    fork
      begin
        for (int i = 0; i < 5; i++) send_model(11'(16 + i * 37), 2'(i));
      end
      begin
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready", 32'(u_if.in_ready), 32'd0);
        chk("bp_accepted", 32'(in_xfers - base), 32'd2);
        chk("bp_out_valid", 32'(u_if.out_valid), 32'd1);
        @(posedge clk); #1;
        u_if.out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_total", 32'(in_xfers - base), 32'd5);
    @(posedge clk); #1;

    // Counter: clear, then 5 overflow transfers saturate at 3.
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) send_model(MIN_V, (i % 2 == 0) ? 2'b01 : 2'b10);
    drain();
    @(negedge clk);
    chk("cnt_sat", 32'(ovf_cnt), 32'd3);
    @(posedge clk); #1;

    // Clear coinciding with an overflowing output transfer.
    cnt_clr = 1'b1;
    send_model(MIN_V, 2'b01);
    drain();
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("cnt_clr_prio", 32'(ovf_cnt), 32'd0);
    @(posedge clk); #1;

    // Random traffic, 1000 words.
    rnd_done = 1'b0;
    fork
      begin
        logic [N-1:0] a;
        for (int w = 0; w < 1000; w++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          a = ($urandom_range(0, 7) == 0) ? MIN_V : N'($urandom);
          send_model(a, 2'($urandom_range(0, 3)));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          u_if.out_ready = 1'($urandom_range(0, 1));
          cnt_clr = ($urandom_range(0, 31) == 0);
        end
        cnt_clr = 1'b0;
        u_if.out_ready = 1'b1;
      end
    join
    drain();
    @(posedge clk); #1;

    // Reset mid-stream with both stages full.
    u_if.out_ready = 1'b0;
    send_model(11'h055, 2'b10);
    send_model(11'h066, 2'b00);
    @(negedge clk);
    chk("full_in_ready", 32'(u_if.in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(u_if.out_valid), 32'd0);
    chk("mid_rst_out_data", 32'(u_if.out_data), 32'd0);
    chk("mid_rst_in_ready", 32'(u_if.in_ready), 32'd1);
    chk("mid_rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    u_if.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_stale_out", 32'(u_if.out_valid), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
